// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: butterfly mode encoding plus rounding and
// saturation helpers. The helpers work on 64-bit signed values; callers size-cast.
package fft_pkg;

  localparam logic MODE_DIT  = 1'b0;
  localparam logic MODE_IDIT = 1'b1;

  // Round half toward +inf, then arithmetic shift right by sh (sh >= 1).
  function automatic logic signed [63:0] rnd_shr(input logic signed [63:0] v, input int sh);
    logic signed [63:0] half;
    half = 64'sd1 <<< (sh - 1);
    return (v + half) >>> sh;
  endfunction

  function automatic logic signed [63:0] sat_dw(input logic signed [63:0] v, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/cmul_round.sv
// Complex multiply t = W*Y (or conj(W)*Y) with rounding, covering the first two
// pipeline stages of the butterfly. Stage loads are driven by the top's handshake.
module cmul_round
  import fft_pkg::*;
#(
  parameter int DW   = 9,
  parameter int TW   = 9,
  parameter int FRAC = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ld_s1,
  input  logic                           ld_s2,
  input  logic                           inverse,
  input  logic signed [DW-1:0]           yr,
  input  logic signed [DW-1:0]           yi,
  input  logic signed [TW-1:0]           wr,
  input  logic signed [TW-1:0]           wi,
  output logic signed [DW+TW+1-FRAC:0]   tr,
  output logic signed [DW+TW+1-FRAC:0]   ti
);

  localparam int PW  = DW + TW + 1;
  localparam int SW  = DW + TW + 2;
  localparam int TRW = SW - FRAC;

  logic signed [DW-1:0]  yr_q, yr_d, yi_q, yi_d;
  logic signed [TW-1:0]  wr_q, wr_d;
  logic signed [TW:0]    wi_q, wi_d, wi_ext;
  logic signed [TRW-1:0] tr_q, tr_d, ti_q, ti_d;
  logic signed [PW-1:0]  p_rr, p_ii, p_ri, p_ir;
  logic signed [SW-1:0]  pr, pi;

  always_comb begin
    yr_d   = yr_q;
    yi_d   = yi_q;
    wr_d   = wr_q;
    wi_d   = wi_q;
    // One extra bit so that negating -2^(TW-1) cannot wrap.
    wi_ext = (TW+1)'(wi);
    if (ld_s1) begin
      yr_d = yr;
      yi_d = yi;
      wr_d = wr;
      unique case (inverse)
        MODE_IDIT: wi_d = -wi_ext;
        MODE_DIT:  wi_d = wi_ext;
      endcase
    end

    p_rr = PW'(wr_q) * PW'(yr_q);
    p_ii = PW'(wi_q) * PW'(yi_q);
    p_ri = PW'(wr_q) * PW'(yi_q);
    p_ir = PW'(wi_q) * PW'(yr_q);
    pr   = SW'(p_rr) - SW'(p_ii);
    pi   = SW'(p_ri) + SW'(p_ir);

    tr_d = ld_s2 ? TRW'(rnd_shr(64'(pr), FRAC)) : tr_q;
    ti_d = ld_s2 ? TRW'(rnd_shr(64'(pi), FRAC)) : ti_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      yr_q <= '0;
      yi_q <= '0;
      wr_q <= '0;
      wi_q <= '0;
      tr_q <= '0;
      ti_q <= '0;
    end else begin
      yr_q <= yr_d;
      yi_q <= yi_d;
      wr_q <= wr_d;
      wi_q <= wi_d;
      tr_q <= tr_d;
      ti_q <= ti_d;
    end
  end

  assign tr = tr_q;
  assign ti = ti_q;

endmodule

// File: rtl/bfly_r2_pipe.sv
// Three-stage radix-2 DIT/IDIT butterfly with valid/ready flow control,
// optional /2 scaling, saturation and sticky overflow reporting.
module bfly_r2_pipe
  import fft_pkg::*;
#(
  parameter int DW   = 9,
  parameter int TW   = 9,
  parameter int FRAC = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 inverse,
  input  logic                 scale,
  input  logic signed [DW-1:0] xr,
  input  logic signed [DW-1:0] xi,
  input  logic signed [DW-1:0] yr,
  input  logic signed [DW-1:0] yi,
  input  logic signed [TW-1:0] wr,
  input  logic signed [TW-1:0] wi,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] x0r,
  output logic signed [DW-1:0] x0i,
  output logic signed [DW-1:0] x1r,
  output logic signed [DW-1:0] x1i,
  output logic                 ovf,
  output logic                 ovf_sticky,
  input  logic                 clr_ovf
);

  localparam int TRW = DW + TW + 2 - FRAC;

  logic en, ld1, ld2, ld3;
  logic v1_q, v1_d, v2_q, v2_d, vo_q, vo_d;
  logic signed [DW-1:0] s1_xr_q, s1_xr_d, s1_xi_q, s1_xi_d;
  logic signed [DW-1:0] s2_xr_q, s2_xr_d, s2_xi_q, s2_xi_d;
  logic s1_scale_q, s1_scale_d, s2_scale_q, s2_scale_d;
  logic signed [DW-1:0] x0r_q, x0r_d, x0i_q, x0i_d, x1r_q, x1r_d, x1i_q, x1i_d;
  logic ovf_q, ovf_d, sticky_q, sticky_d;
  logic signed [TRW-1:0] tr, ti;
  logic signed [63:0] sum [4];
  logic signed [63:0] pre [4];
  logic signed [DW-1:0] sat [4];
  logic clip;

  // A stage loads only when the pipe advances and its upstream stage holds a sample.
  assign en  = !vo_q || out_ready;
  assign ld1 = en && in_valid;
  assign ld2 = en && v1_q;
  assign ld3 = en && v2_q;

  cmul_round #(.DW(DW), .TW(TW), .FRAC(FRAC)) u_cmul (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld_s1   (ld1),
    .ld_s2   (ld2),
    .inverse (inverse),
    .yr      (yr),
    .yi      (yi),
    .wr      (wr),
    .wi      (wi),
    .tr      (tr),
    .ti      (ti)
  );

  always_comb begin
    v1_d       = en ? in_valid : v1_q;
    v2_d       = en ? v1_q     : v2_q;
    vo_d       = en ? v2_q     : vo_q;
    s1_xr_d    = ld1 ? xr    : s1_xr_q;
    s1_xi_d    = ld1 ? xi    : s1_xi_q;
    s1_scale_d = ld1 ? scale : s1_scale_q;
    s2_xr_d    = ld2 ? s1_xr_q    : s2_xr_q;
    s2_xi_d    = ld2 ? s1_xi_q    : s2_xi_q;
    s2_scale_d = ld2 ? s1_scale_q : s2_scale_q;

    sum[0] = 64'(s2_xr_q) + 64'(tr);
    sum[1] = 64'(s2_xi_q) + 64'(ti);
    sum[2] = 64'(s2_xr_q) - 64'(tr);
    sum[3] = 64'(s2_xi_q) - 64'(ti);
    clip   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pre[i] = s2_scale_q ? rnd_shr(sum[i], 1) : sum[i];
      sat[i] = DW'(sat_dw(pre[i], DW));
      clip   = clip | (64'(sat[i]) != pre[i]);
    end

    x0r_d = ld3 ? sat[0] : x0r_q;
    x0i_d = ld3 ? sat[1] : x0i_q;
    x1r_d = ld3 ? sat[2] : x1r_q;
    x1i_d = ld3 ? sat[3] : x1i_q;
    ovf_d = ld3 ? clip   : ovf_q;

    // A fresh overflow wins over a same-cycle clear.
    sticky_d = (vo_q && ovf_q) ? 1'b1 : (clr_ovf ? 1'b0 : sticky_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      vo_q       <= 1'b0;
      s1_xr_q    <= '0;
      s1_xi_q    <= '0;
      s1_scale_q <= 1'b0;
      s2_xr_q    <= '0;
      s2_xi_q    <= '0;
      s2_scale_q <= 1'b0;
      x0r_q      <= '0;
      x0i_q      <= '0;
      x1r_q      <= '0;
      x1i_q      <= '0;
      ovf_q      <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      vo_q       <= vo_d;
      s1_xr_q    <= s1_xr_d;
      s1_xi_q    <= s1_xi_d;
      s1_scale_q <= s1_scale_d;
      s2_xr_q    <= s2_xr_d;
      s2_xi_q    <= s2_xi_d;
      s2_scale_q <= s2_scale_d;
      x0r_q      <= x0r_d;
      x0i_q      <= x0i_d;
      x1r_q      <= x1r_d;
      x1i_q      <= x1i_d;
      ovf_q      <= ovf_d;
      sticky_q   <= sticky_d;
    end
  end

  assign in_ready   = en;
  assign out_valid  = vo_q;
  assign x0r        = x0r_q;
  assign x0i        = x0i_q;
  assign x1r        = x1r_q;
  assign x1i        = x1i_q;
  assign ovf        = ovf_q;
  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_bfly_r2_pipe.sv
// Self-checking bench for bfly_r2_pipe: directed spec vectors, backpressure,
// reset mid-stream, sticky clear, then random traffic against an integer model.
module tb_bfly_r2_pipe;

  localparam int DW   = 9;
  localparam int TW   = 9;
  localparam int FRAC = 8;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, inverse = 1'b0, scale = 1'b0, out_ready = 1'b1, clr_ovf = 1'b0;
  logic signed [DW-1:0] xr = '0, xi = '0, yr = '0, yi = '0;
  logic signed [TW-1:0] wr = '0, wi = '0;
  logic in_ready, out_valid, ovf, ovf_sticky;
  logic signed [DW-1:0] x0r, x0i, x1r, x1i;

  bfly_r2_pipe #(.DW(DW), .TW(TW), .FRAC(FRAC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .inverse(inverse), .scale(scale), .xr(xr), .xi(xi), .yr(yr), .yi(yi),
    .wr(wr), .wi(wi), .out_valid(out_valid), .out_ready(out_ready),
    .x0r(x0r), .x0i(x0i), .x1r(x1r), .x1i(x1i), .ovf(ovf),
    .ovf_sticky(ovf_sticky), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  typedef struct { int xr, xi, yr, yi, wr, wi; bit inv, scl; } smp_t;
  typedef struct { int x0r, x0i, x1r, x1i; bit ovf; int cyc; } exp_t;

  int   n_chk = 0, n_fail = 0, cyc = 0;
  bit   exp_sticky = 1'b0, lat_chk = 1'b0, prev_stall = 1'b0;
  logic [4*DW:0] prev_out = '0;
  exp_t q[$];
  smp_t cur_smp;
  smp_t idle_smp = '{0, 0, 0, 0, 0, 0, 1'b0, 1'b0};

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clampv(input int v, inout bit o);
    int hi, lo;
    hi = (1 <<< (DW - 1)) - 1;
    lo = -(1 <<< (DW - 1));
    if (v > hi) begin o = 1'b1; return hi; end
    if (v < lo) begin o = 1'b1; return lo; end
    return v;
  endfunction

  // Reference: t = W*Y (conjugated W in inverse mode), rounded half-up, then X +/- t.
  function automatic exp_t model(input smp_t s);
    exp_t e;
    int wie, pr, pi, tr, ti;
    int v[4];
    bit o;
    wie = s.inv ? -s.wi : s.wi;
    pr  = s.wr * s.yr - wie * s.yi;
    pi  = s.wr * s.yi + wie * s.yr;
    tr  = (pr + (1 <<< (FRAC - 1))) >>> FRAC;
    ti  = (pi + (1 <<< (FRAC - 1))) >>> FRAC;
    v[0] = s.xr + tr; v[1] = s.xi + ti; v[2] = s.xr - tr; v[3] = s.xi - ti;
    o = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (s.scl) v[i] = (v[i] + 1) >>> 1;
      v[i] = clampv(v[i], o);
    end
    e.x0r = v[0]; e.x0i = v[1]; e.x1r = v[2]; e.x1i = v[3]; e.ovf = o; e.cyc = 0;
    return e;
  endfunction

  task automatic apply(input smp_t s, input bit v);
    cur_smp  = s;
    in_valid = v;
    xr = DW'(s.xr); xi = DW'(s.xi); yr = DW'(s.yr); yi = DW'(s.yi);
    wr = TW'(s.wr); wi = TW'(s.wi);
    inverse = s.inv; scale = s.scl;
  endtask

  // Called at a falling edge: checks outputs, advances model, steps one clock.
  task automatic tick(output bit acc);
    exp_t h;
    logic [4*DW:0] cur;
    bit head_ovf;
    #1;
    cur = {x0r, x0i, x1r, x1i, ovf};
    chk("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
    if (prev_stall) chk("stall_hold", 32'(cur === prev_out), 1);
    prev_stall = out_valid && !out_ready;
    prev_out   = cur;
    head_ovf   = 1'b0;
    if (out_valid === 1'b1) begin
      chk("stale_out", 32'(q.size() > 0), 1);
      if (q.size() > 0) begin
        h = q[0];
        head_ovf = h.ovf;
        chk("x0r", 32'(x0r), h.x0r);
        chk("x0i", 32'(x0i), h.x0i);
        chk("x1r", 32'(x1r), h.x1r);
        chk("x1i", 32'(x1i), h.x1i);
        chk("ovf", 32'(ovf), 32'(h.ovf));
        if (out_ready) begin
          if (lat_chk) chk("latency", cyc - h.cyc, 3);
          void'(q.pop_front());
        end
      end
    end
    chk("ovf_sticky", 32'(ovf_sticky), 32'(exp_sticky));
    if (out_valid === 1'b1 && head_ovf) exp_sticky = 1'b1;
    else if (clr_ovf) exp_sticky = 1'b0;
    acc = in_valid && in_ready;
    if (acc) begin
      h = model(cur_smp);
      h.cyc = cyc;
      q.push_back(h);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    bit acc;
    apply(idle_smp, 1'b0);
    repeat (n) tick(acc);
  endtask

  task automatic send(input smp_t s);
    bit acc;
    bit done;
    done = 1'b0;
    apply(s, 1'b1);
    for (int k = 0; k < 20 && !done; k++) begin
      tick(acc);
      done = acc;
    end
    if (!done) chk("accept_timeout", 0, 1);
    apply(idle_smp, 1'b0);
  endtask

  // Pin the most recently accepted sample's expected result to literal values.
  task automatic set_last(input int a, input int b, input int c, input int d, input bit o);
    if (q.size() > 0) begin
      q[q.size()-1].x0r = a; q[q.size()-1].x0i = b;
      q[q.size()-1].x1r = c; q[q.size()-1].x1i = d;
      q[q.size()-1].ovf = o;
    end
  endtask

  function automatic smp_t rnd_smp();
    smp_t s;
    s.xr = int'($urandom_range(0, 511)) - 256;
    s.xi = int'($urandom_range(0, 511)) - 256;
    s.yr = int'($urandom_range(0, 511)) - 256;
    s.yi = int'($urandom_range(0, 511)) - 256;
    s.wr = int'($urandom_range(0, 511)) - 256;
    s.wi = int'($urandom_range(0, 511)) - 256;
    s.inv = 1'($urandom_range(0, 1));
    s.scl = 1'($urandom_range(0, 1));
    return s;
  endfunction

  initial begin
    bit acc;
    bit pat [4];
    smp_t bp [6];
    smp_t s;
    int idx;

    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_x0r", 32'(x0r), 0);
    chk("rst_x1i", 32'(x1i), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_sticky", 32'(ovf_sticky), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    rst_n = 1'b1;

    // Basic DIT, inverse pair back-to-back, saturation/scale, twiddle extreme
    lat_chk = 1'b1;
    send('{10, 0, 100, 0, 128, 0, 1'b0, 1'b0});   set_last(60, 0, -40, 0, 1'b0);
    idle(5);
    send('{0, 0, 100, 0, 0, 128, 1'b0, 1'b0});    set_last(0, 50, 0, -50, 1'b0);
    send('{0, 0, 100, 0, 0, 128, 1'b1, 1'b0});    set_last(0, -50, 0, 50, 1'b0);
    idle(5);
    send('{200, 0, 200, 0, 255, 0, 1'b0, 1'b0});  set_last(255, 0, 1, 0, 1'b1);
    send('{200, 0, 200, 0, 255, 0, 1'b0, 1'b1});  set_last(200, 0, 1, 0, 1'b0);
    idle(5);
    chk("sticky_after_sat", 32'(ovf_sticky), 1);
    send('{0, 0, 100, 0, 0, -256, 1'b1, 1'b0});   set_last(0, 100, 0, -100, 1'b0);
    idle(5);

    // Backpressure: 6 samples with out_ready pattern 1,0,0,1
    lat_chk = 1'b0;
    for (int i = 0; i < 6; i++) bp[i] = rnd_smp();
    idx = 0;
    for (int k = 0; k < 80 && (idx < 6 || q.size() > 0); k++) begin
      out_ready = pat[k % 4];
      if (idx < 6) apply(bp[idx], 1'b1);
      else apply(idle_smp, 1'b0);
      tick(acc);
      if (acc) idx++;
    end
    out_ready = 1'b1;
    chk("bp_all_sent", idx, 6);
    chk("bp_drained", q.size(), 0);
    idle(2);

    // Reset with two samples in flight and sticky set
    send('{200, 0, 200, 0, 255, 0, 1'b0, 1'b0});
    idle(4);
    send(rnd_smp());
    send(rnd_smp());
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(out_valid), 0);
    chk("rst_mid_sticky", 32'(ovf_sticky), 0);
    chk("rst_mid_x0r", 32'(x0r), 0);
    q.delete();
    exp_sticky = 1'b0;
    prev_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(6);

    // Sticky clear, then set-wins when clear coincides with an overflow
    send('{200, 0, 200, 0, 255, 0, 1'b0, 1'b0});
    idle(5);
    chk("sticky_pre_clr", 32'(ovf_sticky), 1);
    clr_ovf = 1'b1;
    idle(1);
    clr_ovf = 1'b0;
    idle(1);
    chk("sticky_cleared", 32'(ovf_sticky), 0);
    send('{-200, 0, 200, 0, 255, 0, 1'b0, 1'b0});
    clr_ovf = 1'b1;
    idle(6);
    clr_ovf = 1'b0;
    idle(1);

    // Random traffic with random stalls and modes
    for (int k = 0; k < 300; k++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      clr_ovf   = ($urandom_range(0, 15) == 0);
      s = rnd_smp();
      apply(s, 1'($urandom_range(0, 1)));
      tick(acc);
    end
    out_ready = 1'b1;
    clr_ovf   = 1'b0;
    apply(idle_smp, 1'b0);
    for (int k = 0; k < 20 && q.size() > 0; k++) tick(acc);
    chk("final_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
